// File: rtl/an_barrett_seq_pkg.sv
// an_pkg: AN-code (A = 13) constants and the Barrett sequencer state encoding.
package an_pkg;
   localparam int CW_W  = 7;
   localparam int A     = 13;
   localparam int K     = 8;
   localparam int MU    = 19;
   localparam int MSG_W = 3;
   localparam int P_W   = CW_W + 5;
   typedef enum logic [2:0] {ST_IDLE, ST_MU, ST_AM, ST_SUB, ST_FIX, ST_OUT} state_t;
endpackage

// File: rtl/an_barrett_seq_if.sv
// an_barrett_seq_if: valid/ready codeword-in / message-out bus; err_cnt exists only with AN_ERR_CNT_EN.
interface an_barrett_seq_if;
   import an_pkg::*;
   logic             in_valid;
   logic             in_ready;
   logic [CW_W-1:0]  in_cw;
   logic             out_valid;
   logic             out_ready;
   logic [MSG_W-1:0] out_msg;
   logic             out_corr;
   logic             out_err;
`ifdef AN_ERR_CNT_EN
   logic [15:0]      err_cnt;
   modport slave  (input in_valid, in_cw, out_ready, output in_ready, out_valid, out_msg, out_corr, out_err, err_cnt);
   modport master (output in_valid, in_cw, out_ready, input in_ready, out_valid, out_msg, out_corr, out_err, err_cnt);
`else
   modport slave  (input in_valid, in_cw, out_ready, output in_ready, out_valid, out_msg, out_corr, out_err);
   modport master (output in_valid, in_cw, out_ready, input in_ready, out_valid, out_msg, out_corr, out_err);
`endif
endinterface

// File: rtl/an_barrett_seq_dec.sv
// an_decoder_n13: maps a corrected (quotient, residue) pair to the message, undoing single-bit +/-2^k errors.
module an_decoder_n13 (
   input  logic [2:0] i_q,
   input  logic [3:0] i_r,
   output logic [2:0] o_msg
);
   logic [2:0] w_ofs;
   // residue 1 and 12 are ambiguous; the lower-weight error (+1 / -1) wins
   always_comb begin
      case (i_r)
         4'd3:                     w_ofs = 3'd7;
         4'd5, 4'd9, 4'd11, 4'd12: w_ofs = 3'd1;
         4'd6:                     w_ofs = 3'd6;
         4'd7:                     w_ofs = 3'd3;
         4'd10:                    w_ofs = 3'd2;
         default:                  w_ofs = 3'd0;
      endcase
   end
   assign o_msg = i_q + w_ofs;
endmodule

// File: rtl/an_barrett_seq.sv
// an_barrett_seq: multi-cycle Barrett reduction (x mod 13) with one shared multiplier feeding an_decoder_n13.
// Define AN_ERR_CNT_EN to add the saturating err_cnt output.
module an_barrett_seq
   import an_pkg::*;
(
   input logic             clk,
   input logic             rst,
   an_barrett_seq_if.slave bus
);
   state_t           r_state, w_next;
   logic [CW_W-1:0]  r_x, r_p, w_ma;
   logic [4:0]       r_r, w_mb;
   logic [3:0]       r_q, w_qf, w_rf;
   logic [P_W-1:0]   w_prod;
   logic             w_ge, w_err, r_corr, r_err;
   logic [MSG_W-1:0] r_msg, w_dec;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = bus.in_valid ? ST_MU : ST_IDLE;
         ST_MU:   w_next = ST_AM;
         ST_AM:   w_next = ST_SUB;
         ST_SUB:  w_next = ST_FIX;
         ST_FIX:  w_next = ST_OUT;
         ST_OUT:  w_next = bus.out_ready ? ST_IDLE : ST_OUT;
         default: w_next = ST_IDLE;
      endcase
   end
   always_comb begin
      bus.in_ready  = r_state == ST_IDLE;
      bus.out_valid = r_state == ST_OUT;
      w_ma = r_state == ST_AM ? CW_W'(r_q) : r_x;
      w_mb = r_state == ST_AM ? 5'(A) : 5'(MU);
   end
   assign w_prod = P_W'(w_ma) * P_W'(w_mb);
   // r_raw < 2A, so one conditional subtract finishes the reduction
   assign w_ge  = r_r >= 5'(A);
   assign w_qf  = r_q + 4'(w_ge);
   assign w_rf  = 4'(w_ge ? r_r - 5'(A) : r_r);
   assign w_err = w_qf > 4'((1 << MSG_W) - 1);
   an_decoder_n13 u_dec (
      .i_q   (w_qf[2:0]),
      .i_r   (w_rf),
      .o_msg (w_dec)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_x    <= '0;
         r_q    <= '0;
         r_p    <= '0;
         r_r    <= '0;
         r_msg  <= '0;
         r_corr <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && bus.in_valid) r_x <= bus.in_cw;
         if (r_state == ST_MU) r_q <= 4'(w_prod >> K);
         if (r_state == ST_AM) r_p <= CW_W'(w_prod);
         if (r_state == ST_SUB) r_r <= 5'(r_x - r_p);
         if (r_state == ST_FIX) begin
            r_msg  <= w_err ? '0 : w_dec;
            r_corr <= w_rf != 4'd0;
            r_err  <= w_err;
         end
      end
   assign bus.out_msg  = r_msg;
   assign bus.out_corr = r_corr;
   assign bus.out_err  = r_err;
`ifdef AN_ERR_CNT_EN
   logic [15:0] r_err_cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_err_cnt <= '0;
      else if (r_state == ST_OUT && bus.out_ready && (r_corr || r_err) && r_err_cnt != 16'hFFFF)
         r_err_cnt <= r_err_cnt + 16'd1;
   assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_an_barrett_seq.sv
// tb_an_barrett_seq: directed and random codewords checked against a divide-and-search reference decoder.
module tb_an_barrett_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int ecnt = 0;
   an_barrett_seq_if bus ();
   an_barrett_seq dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // find the smallest-magnitude single-bit error e with (x - e) a multiple of 13
   function automatic void model(input int x, output int m, output bit c, output bit e);
      int ev [15] = '{0, 1, -1, 2, -2, 4, -4, 8, -8, 16, -16, 32, -32, 64, -64};
      bit found = 0;
      e = (x / 13) > 7;
      c = (x % 13) != 0;
      m = 0;
      if (!e)
         for (int i = 0; i < 15; i++)
            if (!found && (((x - ev[i]) % 13) + 13) % 13 == 0) begin
               m = ((((x - ev[i]) / 13) % 8) + 8) % 8;
               found = 1;
            end
   endfunction
   task automatic run(input int cw, input int stall);
      int n, em;
      bit ec, ee;
      model(cw, em, ec, ee);
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_idle", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_cw = 7'(cw);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("in_ready_busy", int'(bus.in_ready), 0);
      n = 0;
      while (!bus.out_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, 4);
      chk("msg", int'(bus.out_msg), em);
      chk("corr", int'(bus.out_corr), int'(ec));
      chk("err", int'(bus.out_err), int'(ee));
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;
         bus.in_cw = 7'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", int'(bus.out_valid), 1);
         chk("hold_ready", int'(bus.in_ready), 0);
         chk("hold_msg", int'(bus.out_msg), em);
         chk("hold_corr", int'(bus.out_corr), int'(ec));
         chk("hold_err", int'(bus.out_err), int'(ee));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b0;
      if ((ec || ee) && ecnt < 65535) ecnt++;
      chk("post_valid", int'(bus.out_valid), 0);
      chk("post_ready", int'(bus.in_ready), 1);
`ifdef AN_ERR_CNT_EN
      chk("err_cnt", int'(bus.err_cnt), ecnt);
`endif
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.in_cw = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_msg", int'(bus.out_msg), 0);
      chk("rst_corr", int'(bus.out_corr), 0);
      chk("rst_err", int'(bus.out_err), 0);
`ifdef AN_ERR_CNT_EN
      chk("rst_err_cnt", int'(bus.err_cnt), 0);
`endif
      run(26, 0);
      run(47, 0);
      run(65, 0);
      run(117, 0);
      run(39, 10);
      run(26, 3);
      run(47, 0);
      bus.in_valid = 1'b1;
      bus.in_cw = 7'd26;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      ecnt = 0;
      chk("amrst_in_ready", int'(bus.in_ready), 1);
      chk("amrst_out_valid", int'(bus.out_valid), 0);
      chk("amrst_msg", int'(bus.out_msg), 0);
      chk("amrst_corr", int'(bus.out_corr), 0);
      chk("amrst_err", int'(bus.out_err), 0);
`ifdef AN_ERR_CNT_EN
      chk("amrst_err_cnt", int'(bus.err_cnt), 0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      run(26, 0);
      for (int i = 0; i < 128; i++) run(i, 0);
      for (int i = 0; i < 200; i++) run(int'($urandom_range(127)), int'($urandom_range(3)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
